// File: rtl/audio_dac_i2s_serializer_pkg.sv
// Shared types for the I2S DAC serializer: FSM state encoding and the stereo
// sample pair that is stored in the FIFO.
package audio_pkg;

  localparam int SAMPLE_W_DEF = 16;

  typedef enum logic [1:0] {
    ALIGN = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_state_t;

  typedef struct packed {
    logic [SAMPLE_W_DEF-1:0] l;
    logic [SAMPLE_W_DEF-1:0] r;
  } sample_pair_t;

endpackage

// File: rtl/audio_dac_i2s_serializer_if.sv
// Upstream valid/ready stream carrying one stereo PCM pair per transfer.
interface audio_dac_i2s_serializer_if #(
  parameter int SAMPLE_W = 16
);

  logic                valid;
  logic                ready;
  logic [SAMPLE_W-1:0] left;
  logic [SAMPLE_W-1:0] right;

  modport master (output valid, output left, output right, input ready);
  modport slave  (input valid, input left, input right, output ready);

endinterface

// File: rtl/audio_dac_i2s_serializer_fifo.sv
// Synchronous first-word-fall-through FIFO of stereo pairs; a full FIFO
// refuses pushes even when a pop happens in the same cycle.
module audio_pair_fifo
  import audio_pkg::*;
#(
  parameter type T     = sample_pair_t,
  parameter int  DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  T                       din,
  output T                       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  T               mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic           push_s, pop_s;

  assign full   = (level_q == LW'(DEPTH));
  assign empty  = (level_q == LW'(0));
  assign push_s = push & ~full;
  assign pop_s  = pop & ~empty;
  assign dout   = mem_q[rd_ptr_q];
  assign level  = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      level_q  <= LW'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; pointers and level alone define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/audio_dac_i2s_serializer.sv
// I2S serializer for a codec-mastered DAC: buffers stereo pairs and shifts them
// out MSB first on DACDAT one bit clock after each LR clock boundary.
module audio_dac_i2s_serializer
  import audio_pkg::*;
#(
  parameter int SAMPLE_W    = SAMPLE_W_DEF,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  audio_dac_i2s_serializer_if.slave     s,
  input  logic                          audio_0_external_interface_BCLK,
  input  logic                          audio_0_external_interface_DACLRCK,
  output logic                          audio_0_external_interface_DACDAT,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun
);

  localparam int CW = $clog2(SAMPLE_W + 1);

  typedef struct packed {
    logic [SAMPLE_W-1:0] l;
    logic [SAMPLE_W-1:0] r;
  } pair_t;

  logic [SYNC_STAGES-1:0] bclk_sync_q, lrck_sync_q;
  logic                   bclk_s, lrck_s;
  logic                   bclk_prev_q;
  logic                   rise_ev_s, fall_ev_s;
  logic                   rise_dly_q, rise_dly_d;
  logic                   lr_cur_q, lr_cur_d, lr_prev_q, lr_prev_d;
  logic                   boundary_s, left_start_s, right_start_s;

  i2s_state_t             state_q, state_d;
  logic [SAMPLE_W-1:0]    sh_q, sh_d, hold_q, hold_d;
  logic [CW-1:0]          bitcnt_q, bitcnt_d;
  logic                   word_act_q, word_act_d;
  logic                   dacdat_q, dacdat_d;
  logic                   underrun_q, underrun_d;

  pair_t                  fifo_din_s, fifo_dout_s;
  logic                   fifo_push_s, fifo_full_s, fifo_empty_s;

  assign fifo_din_s  = {s.left, s.right};
  assign s.ready     = ~fifo_full_s;
  assign fifo_push_s = s.valid & ~fifo_full_s;

  audio_pair_fifo #(
    .T     (pair_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .push  (fifo_push_s),
    .pop   (left_start_s),
    .din   (fifo_din_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (fifo_level)
  );

  // Both codec clocks go through identical chains so their relative phase survives.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      bclk_sync_q <= {SYNC_STAGES{1'b0}};
      lrck_sync_q <= {SYNC_STAGES{1'b0}};
      bclk_prev_q <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], audio_0_external_interface_BCLK};
      lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], audio_0_external_interface_DACLRCK};
      bclk_prev_q <= bclk_s;
    end
  end

  assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
  assign lrck_s    = lrck_sync_q[SYNC_STAGES-1];
  assign rise_ev_s = bclk_s & ~bclk_prev_q;
  assign fall_ev_s = ~bclk_s & bclk_prev_q;

  // A boundary is judged the cycle after the rise that captured the new LR level.
  assign boundary_s    = rise_dly_q & (lr_cur_q != lr_prev_q);
  assign left_start_s  = boundary_s & ~lr_cur_q;
  assign right_start_s = boundary_s & lr_cur_q;

  always_comb begin
    rise_dly_d = rise_ev_s;
    if (rise_ev_s) begin
      lr_cur_d  = lrck_s;
      lr_prev_d = lr_cur_q;
    end else begin
      lr_cur_d  = lr_cur_q;
      lr_prev_d = lr_prev_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    hold_d     = hold_q;
    bitcnt_d   = bitcnt_q;
    word_act_d = word_act_q;
    dacdat_d   = dacdat_q;
    underrun_d = 1'b0;

    case (state_q)
      ALIGN: begin
        if (left_start_s) state_d = LEFT;
        else              state_d = ALIGN;
      end
      LEFT: begin
        if (right_start_s) state_d = RIGHT;
        else               state_d = LEFT;
      end
      RIGHT: begin
        if (left_start_s) state_d = LEFT;
        else              state_d = RIGHT;
      end
      default: state_d = ALIGN;
    endcase

    // A new start always wins over any bits left from a short slot.
    if (left_start_s) begin
      bitcnt_d   = CW'(SAMPLE_W);
      word_act_d = 1'b1;
      if (!fifo_empty_s) begin
        sh_d   = fifo_dout_s.l;
        hold_d = fifo_dout_s.r;
      end else begin
        sh_d       = {SAMPLE_W{1'b0}};
        hold_d     = {SAMPLE_W{1'b0}};
        underrun_d = 1'b1;
      end
    end else if (right_start_s && (state_q != ALIGN)) begin
      sh_d       = hold_q;
      bitcnt_d   = CW'(SAMPLE_W);
      word_act_d = 1'b1;
    end else if (fall_ev_s) begin
      if (word_act_q && (state_q != ALIGN)) begin
        dacdat_d   = sh_q[SAMPLE_W-1];
        sh_d       = {sh_q[SAMPLE_W-2:0], 1'b0};
        bitcnt_d   = bitcnt_q - CW'(1);
        word_act_d = (bitcnt_q != CW'(1));
      end else begin
        dacdat_d = 1'b0;
      end
    end else begin
      dacdat_d = dacdat_q;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rise_dly_q <= 1'b0;
      lr_cur_q   <= 1'b0;
      lr_prev_q  <= 1'b0;
      state_q    <= ALIGN;
      sh_q       <= {SAMPLE_W{1'b0}};
      hold_q     <= {SAMPLE_W{1'b0}};
      bitcnt_q   <= CW'(0);
      word_act_q <= 1'b0;
      dacdat_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      rise_dly_q <= rise_dly_d;
      lr_cur_q   <= lr_cur_d;
      lr_prev_q  <= lr_prev_d;
      state_q    <= state_d;
      sh_q       <= sh_d;
      hold_q     <= hold_d;
      bitcnt_q   <= bitcnt_d;
      word_act_q <= word_act_d;
      dacdat_q   <= dacdat_d;
      underrun_q <= underrun_d;
    end
  end

  assign audio_0_external_interface_DACDAT = dacdat_q;
  assign underrun                          = underrun_q;

endmodule
